// File: rtl/arb_pkg.sv
// Shared definitions for the memory bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> REQ -> RESP -> IDLE)
//   master_t    : master identifiers (IFU = 0, LSU = 1)
//   ARB_TIMEOUT_DEFAULT : default response-watchdog limit in cycles
//   wd_width()  : watchdog counter width for a given limit (at least 8 bits)
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    M_IFU = 1'b0,
    M_LSU = 1'b1
  } master_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

  function automatic int unsigned wd_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Response watchdog for mem_bus_arbiter (built only when ARB_TIMEOUT_EN is defined).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : hold the count at zero (arbiter idle, so the count starts at 0 on REQ entry)
//   run       : transaction in flight (REQ or RESP); count advances each cycle
//   expired   : count has reached TIMEOUT while running
module arb_watchdog
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = wd_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Saturates at LIMIT so a handshake arriving on the expiry cycle
  // still leaves expired asserted for the following state.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run && (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory port arbiter (IFU fetch, LSU load/store), one outstanding
// transaction, valid/ready request and response handshakes.
// Optional feature: define ARB_TIMEOUT_EN to build a response watchdog that
// completes a stalled transaction with an error response after TIMEOUT cycles.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr  : IFU request (read only)
//   ifu_resp_valid/rdata/resp_err  : IFU response (single-cycle pulse)
//   lsu_req_valid/ready, lsu_addr, lsu_we, lsu_wdata, lsu_wmask : LSU request
//   lsu_resp_valid/rdata/resp_err  : LSU response (single-cycle pulse)
//   s_req_valid/ready, s_addr, s_we, s_wdata, s_wmask : request to memory
//   s_resp_valid, s_rdata, s_resp_err                 : response from memory
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  // IFU
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [WIDTH-1:0]   ifu_addr,
  output logic               ifu_resp_valid,
  output logic [WIDTH-1:0]   ifu_rdata,
  output logic               ifu_resp_err,
  // LSU
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [WIDTH-1:0]   lsu_addr,
  input  logic               lsu_we,
  input  logic [WIDTH-1:0]   lsu_wdata,
  input  logic [WIDTH/8-1:0] lsu_wmask,
  output logic               lsu_resp_valid,
  output logic [WIDTH-1:0]   lsu_rdata,
  output logic               lsu_resp_err,
  // memory side
  output logic               s_req_valid,
  input  logic               s_req_ready,
  output logic [WIDTH-1:0]   s_addr,
  output logic               s_we,
  output logic [WIDTH-1:0]   s_wdata,
  output logic [WIDTH/8-1:0] s_wmask,
  input  logic               s_resp_valid,
  input  logic [WIDTH-1:0]   s_rdata,
  input  logic               s_resp_err
);

  arb_state_t         state;
  master_t            last_grant;
  master_t            owner;
  logic [WIDTH-1:0]   lat_addr;
  logic               lat_we;
  logic [WIDTH-1:0]   lat_wdata;
  logic [WIDTH/8-1:0] lat_wmask;

  logic grant_ifu;
  logic grant_lsu;
  logic expired;
  logic resp_fire;
  logic timeout_fire;
  logic done;

`ifdef ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_IDLE),
    .run     (state != ST_IDLE),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Single valid master wins; on a tie the master not granted last wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst && (state == ST_IDLE)) begin
      grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_grant == M_LSU));
      grant_lsu = lsu_req_valid && !grant_ifu;
    end
  end

  // A real handshake always beats the watchdog on the same cycle.
  always_comb begin
    resp_fire    = !rst && (state == ST_RESP) && s_resp_valid;
    timeout_fire = !rst && expired &&
                   (((state == ST_REQ)  && !s_req_ready) ||
                    ((state == ST_RESP) && !s_resp_valid));
    done         = resp_fire || timeout_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= M_LSU;
      owner      <= M_IFU;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ifu || grant_lsu) begin
            state      <= ST_REQ;
            owner      <= grant_lsu ? M_LSU : M_IFU;
            last_grant <= grant_lsu ? M_LSU : M_IFU;
            lat_addr   <= grant_lsu ? lsu_addr : ifu_addr;
            lat_we     <= grant_lsu && lsu_we;
            lat_wdata  <= grant_lsu ? lsu_wdata : '0;
            lat_wmask  <= grant_lsu ? lsu_wmask : '1;
          end
        end
        ST_REQ: begin
          if (s_req_ready) begin
            state <= ST_RESP;
          end else if (timeout_fire) begin
            state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ifu_req_ready  = grant_ifu;
    lsu_req_ready  = grant_lsu;

    s_req_valid    = !rst && (state == ST_REQ);
    s_addr         = lat_addr;
    s_we           = lat_we;
    s_wdata        = lat_wdata;
    s_wmask        = lat_wmask;

    ifu_resp_valid = done && (owner == M_IFU);
    lsu_resp_valid = done && (owner == M_LSU);

    // Watchdog completions carry err = 1 and rdata = 0.
    ifu_rdata      = (resp_fire && (owner == M_IFU)) ? s_rdata : '0;
    lsu_rdata      = (resp_fire && (owner == M_LSU)) ? s_rdata : '0;
    ifu_resp_err   = ifu_resp_valid && (resp_fire ? s_resp_err : 1'b1);
    lsu_resp_err   = lsu_resp_valid && (resp_fire ? s_resp_err : 1'b1);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit later.
module tb_mem_bus_arbiter;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [W-1:0]  ifu_addr, ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid, lsu_resp_err;
  logic [W-1:0]  lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]    lsu_wmask;
  logic          s_req_valid, s_req_ready, s_we, s_resp_valid, s_resp_err;
  logic [W-1:0]  s_addr, s_wdata, s_rdata;
  logic [3:0]    s_wmask;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .WIDTH   (W),
    .TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_we         (lsu_we),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .lsu_resp_err   (lsu_resp_err),
    .s_req_valid    (s_req_valid),
    .s_req_ready    (s_req_ready),
    .s_addr         (s_addr),
    .s_we           (s_we),
    .s_wdata        (s_wdata),
    .s_wmask        (s_wmask),
    .s_resp_valid   (s_resp_valid),
    .s_rdata        (s_rdata),
    .s_resp_err     (s_resp_err)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_we = 0; lsu_wdata = '0; lsu_wmask = '0;
    s_req_ready = 0; s_resp_valid = 0; s_rdata = '0; s_resp_err = 0;
    next_cycle;
    next_cycle;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ifu_rdy"}, W'(ifu_req_ready), W'(0));
    chk({tag, "_lsu_rdy"}, W'(lsu_req_ready), W'(0));
    chk({tag, "_ifu_rv"},  W'(ifu_resp_valid), W'(0));
    chk({tag, "_lsu_rv"},  W'(lsu_resp_valid), W'(0));
    chk({tag, "_ifu_rd"},  ifu_rdata, W'(0));
    chk({tag, "_lsu_rd"},  lsu_rdata, W'(0));
    chk({tag, "_ifu_err"}, W'(ifu_resp_err), W'(0));
    chk({tag, "_lsu_err"}, W'(lsu_resp_err), W'(0));
    chk({tag, "_s_rv"},    W'(s_req_valid), W'(0));
    chk({tag, "_s_addr"},  s_addr, W'(0));
    chk({tag, "_s_we"},    W'(s_we), W'(0));
    chk({tag, "_s_wdata"}, s_wdata, W'(0));
    chk({tag, "_s_wmask"}, W'(s_wmask), W'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // ---------------- reset state ----------------
    do_reset;
    settle;
    chk_all_zero("reset");

    // ---------------- 1: IFU only ----------------
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; s_req_ready = 1;
    settle;
    chk("t1_ifu_rdy", W'(ifu_req_ready), W'(1));
    chk("t1_lsu_rdy", W'(lsu_req_ready), W'(0));
    chk("t1_s_rv_idle", W'(s_req_valid), W'(0));
    next_cycle;                              // REQ
    ifu_req_valid = 0;
    settle;
    chk("t1_s_rv", W'(s_req_valid), W'(1));
    chk("t1_s_addr", s_addr, 32'h8000_0000);
    chk("t1_s_we", W'(s_we), W'(0));
    chk("t1_rv_early", W'(ifu_resp_valid), W'(0));
    next_cycle;                              // RESP
    s_resp_valid = 1; s_rdata = 32'h0000_0413;
    settle;
    chk("t1_ifu_rv", W'(ifu_resp_valid), W'(1));
    chk("t1_ifu_rd", ifu_rdata, 32'h0000_0413);
    chk("t1_ifu_err", W'(ifu_resp_err), W'(0));
    chk("t1_lsu_rv", W'(lsu_resp_valid), W'(0));
    chk("t1_s_rv_resp", W'(s_req_valid), W'(0));
    next_cycle;                              // IDLE
    s_resp_valid = 0;
    settle;
    chk("t1_ifu_rv_after", W'(ifu_resp_valid), W'(0));

    // ---------------- 2: simultaneous from reset ----------------
    do_reset;
    ifu_req_valid = 1; ifu_addr = 32'h0000_1000;
    lsu_req_valid = 1; lsu_addr = 32'h0000_2000; lsu_we = 0;
    s_req_ready = 1;
    settle;
    chk("t2_g1_ifu", W'(ifu_req_ready), W'(1));
    chk("t2_g1_lsu", W'(lsu_req_ready), W'(0));
    next_cycle;                              // REQ (IFU)
    ifu_req_valid = 0;
    settle;
    chk("t2_g1_addr", s_addr, 32'h0000_1000);
    chk("t2_lsu_rdy_busy", W'(lsu_req_ready), W'(0));
    next_cycle;                              // RESP
    s_resp_valid = 1; s_rdata = 32'h1111_1111;
    settle;
    chk("t2_g1_ifu_rv", W'(ifu_resp_valid), W'(1));
    chk("t2_g1_lsu_rv", W'(lsu_resp_valid), W'(0));
    next_cycle;                              // IDLE, both valid again
    s_resp_valid = 0; ifu_req_valid = 1;
    settle;
    chk("t2_g2_lsu", W'(lsu_req_ready), W'(1));
    chk("t2_g2_ifu", W'(ifu_req_ready), W'(0));
    next_cycle;                              // REQ (LSU)
    lsu_req_valid = 0;
    settle;
    chk("t2_g2_addr", s_addr, 32'h0000_2000);
    next_cycle;                              // RESP
    s_resp_valid = 1; s_rdata = 32'h2222_2222;
    settle;
    chk("t2_g2_lsu_rv", W'(lsu_resp_valid), W'(1));
    chk("t2_g2_lsu_rd", lsu_rdata, 32'h2222_2222);
    chk("t2_g2_ifu_rv", W'(ifu_resp_valid), W'(0));
    chk("t2_g2_ifu_rd", ifu_rdata, W'(0));
    next_cycle;                              // IDLE, both valid again
    s_resp_valid = 0; lsu_req_valid = 1;
    settle;
    chk("t2_g3_ifu", W'(ifu_req_ready), W'(1));
    chk("t2_g3_lsu", W'(lsu_req_ready), W'(0));
    next_cycle;                              // REQ (IFU)
    ifu_req_valid = 0; lsu_req_valid = 0;
    settle;
    chk("t2_g3_addr", s_addr, 32'h0000_1000);
    next_cycle;                              // RESP
    s_resp_valid = 1; s_rdata = 32'h3333_3333;
    settle;
    chk("t2_g3_ifu_rv", W'(ifu_resp_valid), W'(1));
    next_cycle;                              // IDLE
    s_resp_valid = 0;

    // ---------------- 3: LSU store with stalled s_req_ready ----------------
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_we = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; s_req_ready = 0;
    settle;
    chk("t3_lsu_rdy", W'(lsu_req_ready), W'(1));
    next_cycle;                              // REQ cycle 1
    lsu_req_valid = 0; lsu_addr = 32'h5555_5555; lsu_we = 0;
    lsu_wdata = 32'hAAAA_AAAA; lsu_wmask = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) s_req_ready = 1;
      settle;
      chk($sformatf("t3_s_rv_%0d", i),    W'(s_req_valid), W'(1));
      chk($sformatf("t3_s_addr_%0d", i),  s_addr, 32'h8000_1000);
      chk($sformatf("t3_s_we_%0d", i),    W'(s_we), W'(1));
      chk($sformatf("t3_s_wdata_%0d", i), s_wdata, 32'hDEAD_BEEF);
      chk($sformatf("t3_s_wmask_%0d", i), W'(s_wmask), W'(4'b0011));
      next_cycle;
    end
    // now in RESP; memory not yet responding
    settle;
    chk("t3_rv_wait", W'(lsu_resp_valid), W'(0));
    chk("t3_s_rv_resp", W'(s_req_valid), W'(0));
    next_cycle;
    s_resp_valid = 1; s_rdata = 32'h0;
    settle;
    chk("t3_lsu_rv", W'(lsu_resp_valid), W'(1));
    chk("t3_lsu_err", W'(lsu_resp_err), W'(0));
    next_cycle;                              // IDLE
    s_resp_valid = 0;

    // ---------------- 6: error passthrough on LSU load ----------------
    lsu_req_valid = 1; lsu_addr = 32'h0000_4000; lsu_we = 0;
    settle;
    chk("t6_lsu_rdy", W'(lsu_req_ready), W'(1));
    next_cycle;                              // REQ
    lsu_req_valid = 0;
    settle;
    chk("t6_s_we", W'(s_we), W'(0));
    next_cycle;                              // RESP
    s_resp_valid = 1; s_resp_err = 1; s_rdata = 32'h1234_5678;
    settle;
    chk("t6_lsu_rv", W'(lsu_resp_valid), W'(1));
    chk("t6_lsu_err", W'(lsu_resp_err), W'(1));
    chk("t6_lsu_rd", lsu_rdata, 32'h1234_5678);
    chk("t6_ifu_rv", W'(ifu_resp_valid), W'(0));
    chk("t6_ifu_err", W'(ifu_resp_err), W'(0));
    chk("t6_ifu_rd", ifu_rdata, W'(0));
    next_cycle;
    s_resp_valid = 0; s_resp_err = 0;

    // ---------------- 4: reset mid-transaction ----------------
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    next_cycle;                              // REQ
    ifu_req_valid = 0;
    next_cycle;                              // RESP, no response yet
    s_req_ready = 0;
    settle;
    chk("t4_in_resp_rv", W'(ifu_resp_valid), W'(0));
    rst = 1;
    next_cycle;                              // IDLE after reset edge
    rst = 0; s_resp_valid = 1; s_rdata = 32'hCAFE_F00D; s_resp_err = 1;
    settle;
    chk_all_zero("t4");
    next_cycle;
    s_resp_valid = 0; s_resp_err = 0;
    settle;
    chk("t4_still_idle", W'(s_req_valid), W'(0));

    // ---------------- 5: timeout (TIMEOUT = 4) ----------------
    s_rdata = 32'hFFFF_FFFF; s_req_ready = 1;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
    settle;
    chk("t5_ifu_rdy", W'(ifu_req_ready), W'(1));
    next_cycle;                              // REQ entry (count 0)
    ifu_req_valid = 0;
    settle;
    chk("t5_s_rv", W'(s_req_valid), W'(1));
    for (int i = 1; i < 4; i++) begin
      next_cycle;
      s_req_ready = 0;
      settle;
      chk($sformatf("t5_wait_rv_%0d", i), W'(ifu_resp_valid), W'(0));
    end
    next_cycle;                              // 4 cycles after REQ entry
    settle;
`ifdef ARB_TIMEOUT_EN
    chk("t5_to_rv",  W'(ifu_resp_valid), W'(1));
    chk("t5_to_err", W'(ifu_resp_err), W'(1));
    chk("t5_to_rd",  ifu_rdata, W'(0));
    chk("t5_to_lsu", W'(lsu_resp_valid), W'(0));
    next_cycle;
    settle;
    chk("t5_idle_s_rv", W'(s_req_valid), W'(0));
    chk("t5_idle_rv", W'(ifu_resp_valid), W'(0));
`else
    chk("t5_stay_rv", W'(ifu_resp_valid), W'(0));
    next_cycle;
    settle;
    chk("t5_stay_rv2", W'(ifu_resp_valid), W'(0));
    chk("t5_stay_nogrant", W'(s_req_valid), W'(0));
    s_resp_valid = 1; s_rdata = 32'h0000_0ABC;
    settle;
    chk("t5_late_rv", W'(ifu_resp_valid), W'(1));
    chk("t5_late_rd", ifu_rdata, 32'h0000_0ABC);
    next_cycle;
    s_resp_valid = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
